// File: rtl/ram_rr_arbiter.sv
// ram_rr_arbiter: round-robin sharing of one RAM port among NREQ requesters
//   CLK, nRST                 clock, asynchronous active-low reset
//   req_ren/wen/blk/addr/store per-requester read, write, two-word block, address, write data
//   req_wait/load/err         per-requester stall, read data, one-cycle abort pulse
//   ramstate/ramload          RAM status (FREE, BUSY, ACCESS, ERROR) and read data
//   ramREN/WEN/addr/store     RAM command
//   busy, owner               transaction in progress, current or last grantee
module ram_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic [NREQ-1:0]          req_ren,
  input  logic [NREQ-1:0]          req_wen,
  input  logic [NREQ-1:0]          req_blk,
  input  logic [NREQ-1:0][AW-1:0]  req_addr,
  input  logic [NREQ-1:0][DW-1:0]  req_store,
  output logic [NREQ-1:0]          req_wait,
  output logic [NREQ-1:0][DW-1:0]  req_load,
  output logic [NREQ-1:0]          req_err,
  input  logic [1:0]               ramstate,
  input  logic [DW-1:0]            ramload,
  output logic                     ramREN,
  output logic                     ramWEN,
  output logic [AW-1:0]            ramaddr,
  output logic [DW-1:0]            ramstore,
  output logic                     busy,
  output logic [$clog2(NREQ)-1:0]  owner
);
  localparam int IW = $clog2(NREQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [1:0] ACCESS = 2'd2, ERROR = 2'd3;
  typedef enum logic [1:0] {IDLE, WORD0, WORD1} state_t;
  state_t state, state_d;
  logic [IW-1:0] rr_ptr, pick;
  logic [WW-1:0] wdog;
  logic [NREQ-1:0] act;
  logic [AW-1:0] addr;
  logic op_wr, blk_q, hit, word, live, acc, err, done;
  assign act = req_ren | req_wen;
  assign word = state != IDLE;
  // live drops the instant the owner withdraws, gating the RAM enables combinationally
  assign live = word & act[owner];
  assign addr = req_addr[owner];
  assign acc = live & (ramstate == ACCESS);
  // ~ramstate[1] selects FREE/BUSY, the only states in which the watchdog runs
  assign err = live & ((ramstate == ERROR) | (~ramstate[1] & (wdog == WW'(TIMEOUT - 1))));
  assign done = word & (~live | err | (acc & ((state == WORD1) | ~blk_q)));
  assign busy = word;
  assign ramREN = live & ~op_wr;
  assign ramWEN = live & op_wr;
  assign ramaddr = ~word ? '0 : (state == WORD1) ? {addr[AW-1:3], 3'b100} : blk_q ? {addr[AW-1:3], 3'b000} : addr;
  assign ramstore = (word & op_wr) ? req_store[owner] : '0;
  assign req_wait = ~(NREQ'(acc) << owner);
  assign req_err = NREQ'(err) << owner;
  always_comb begin
    req_load = '0;
    if (word & ~op_wr) req_load[owner] = ramload;
  end
  // descending scan so the requester closest after rr_ptr is written last and wins
  always_comb begin
    hit = 1'b0;
    pick = rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (act[rr_ptr + IW'(i)]) begin
        hit = 1'b1;
        pick = rr_ptr + IW'(i);
      end
  end
  always_comb begin
    state_d = ~word ? (hit ? WORD0 : IDLE) : done ? IDLE : acc ? WORD1 : state;
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      op_wr <= 1'b0;
      blk_q <= 1'b0;
      wdog <= '0;
    end else begin
      state <= state_d;
      wdog <= (~word | acc) ? '0 : wdog + 1'b1;
      if (~word & hit) begin
        owner <= pick;
        op_wr <= req_wen[pick];
        blk_q <= req_blk[pick];
      end
      if (done) rr_ptr <= owner + 1'b1;
    end
  end
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// tb_ram_rr_arbiter: directed stimulus with a transaction-level reference model
module tb_ram_rr_arbiter;
  localparam int NREQ = 4, AW = 32, DW = 32, TIMEOUT = 4, W = NREQ * DW;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  logic CLK = 1'b0, nRST = 1'b0;
  logic [NREQ-1:0] req_ren = '0, req_wen = '0, req_blk = '0;
  logic [NREQ-1:0][AW-1:0] req_addr = '0;
  logic [NREQ-1:0][DW-1:0] req_store = '0;
  logic [NREQ-1:0] req_wait, req_err;
  logic [NREQ-1:0][DW-1:0] req_load;
  logic [1:0] ramstate = BUSY;
  logic [DW-1:0] ramload = '0;
  logic ramREN, ramWEN, busy;
  logic [AW-1:0] ramaddr;
  logic [DW-1:0] ramstore;
  logic [1:0] owner;
  int n_cmp = 0, n_fail = 0;
  int m_busy = 0, m_own = 0, m_ptr = 0, m_wr = 0, m_blk = 0, m_word = 0, m_stall = 0;

  ram_rr_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .req_ren(req_ren), .req_wen(req_wen), .req_blk(req_blk),
    .req_addr(req_addr), .req_store(req_store), .req_wait(req_wait), .req_load(req_load),
    .req_err(req_err), .ramstate(ramstate), .ramload(ramload), .ramREN(ramREN),
    .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore), .busy(busy), .owner(owner)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
    n_cmp++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Model: one transaction = grant, then 1 or 2 words, each word finishing on ACCESS.
  always @(negedge CLK) begin
    logic [NREQ-1:0] act, e_wait, e_err;
    logic [NREQ-1:0][DW-1:0] e_load;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_store;
    logic e_ren, e_wen, fin;
    int was_busy;
    act = req_ren | req_wen;
    e_wait = 4'hF; e_err = '0; e_load = '0; e_addr = '0; e_store = '0;
    e_ren = 1'b0; e_wen = 1'b0; fin = 1'b0;
    if (!nRST) begin
      m_busy = 0; m_own = 0; m_ptr = 0;
    end else if (m_busy != 0) begin
      e_addr = (m_blk != 0) ? ((req_addr[m_own] & ~32'h7) + 32'(4 * m_word)) : req_addr[m_own];
      e_ren = act[m_own] && m_wr == 0;
      e_wen = act[m_own] && m_wr != 0;
      e_store = (m_wr != 0) ? req_store[m_own] : '0;
      if (m_wr == 0) e_load[m_own] = ramload;
      if (!act[m_own]) fin = 1'b1;
      else if (ramstate == ACCESS) begin
        e_wait[m_own] = 1'b0;
        m_word++;
        m_stall = 0;
        fin = m_word == ((m_blk != 0) ? 2 : 1);
      end else if (ramstate == ERROR || m_stall == TIMEOUT - 1) begin
        e_err[m_own] = 1'b1;
        fin = 1'b1;
      end else m_stall++;
    end
    was_busy = m_busy;
    chk("busy", busy, m_busy != 0);
    chk("owner", owner, m_own);
    chk("ramREN", ramREN, e_ren);
    chk("ramWEN", ramWEN, e_wen);
    chk("ramaddr", ramaddr, e_addr);
    chk("ramstore", ramstore, e_store);
    chk("req_wait", req_wait, e_wait);
    chk("req_err", req_err, e_err);
    chk("req_load", req_load, e_load);
    if (nRST && was_busy != 0 && fin) begin
      m_busy = 0;
      m_ptr = (m_own + 1) % NREQ;
    end else if (nRST && was_busy == 0 && act != 0) begin
      for (int k = NREQ - 1; k >= 0; k--)
        if (act[(m_ptr + k) % NREQ]) m_own = (m_ptr + k) % NREQ;
      m_busy = 1; m_wr = int'(req_wen[m_own]); m_blk = int'(req_blk[m_own]);
      m_word = 0; m_stall = 0;
    end
  end

  initial begin
    logic [NREQ-1:0] ew;
    repeat (2) @(posedge CLK);
    #3;
    chk("rst_wait", req_wait, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_addr", ramaddr, 32'h0);
    // fairness: everyone requesting, grants rotate 0,1,2,3,0
    cyc(); nRST = 1'b1; req_ren = 4'hF; ramstate = ACCESS;
    for (int t = 0; t < 5; t++) begin
      cyc(); #2;
      ew = ~(4'b0001 << (t % NREQ));
      chk("fair_owner", owner, t % NREQ);
      chk("fair_wait", req_wait, ew);
      cyc();
    end
    // single read by requester 2
    req_ren = 4'b0100; req_addr[2] = 32'h104; ramload = 32'hA5A5_0001; ramstate = BUSY;
    cyc(); #2;
    chk("rd_ren", ramREN, 1'b1);
    chk("rd_addr", ramaddr, 32'h104);
    chk("rd_owner", owner, 2);
    cyc();
    cyc(); ramstate = ACCESS; #2;
    chk("rd_wait", req_wait, 4'b1011);
    chk("rd_load", req_load[2], 32'hA5A5_0001);
    // withdrawal: 0 and 3 both ask, pointer sits at 3
    cyc(); req_ren = 4'b1001; ramstate = BUSY; #2;
    chk("rd_done", busy, 1'b0);
    cyc(); #2;
    chk("wd_owner", owner, 3);
    chk("wd_ren", ramREN, 1'b1);
    cyc(); req_ren[3] = 1'b0; #2;
    chk("wd_ren_off", ramREN, 1'b0);
    chk("wd_err", req_err, 4'h0);
    cyc(); #2;
    chk("wd_idle", busy, 1'b0);
    cyc(); ramstate = ACCESS; #2;
    chk("wd_next", owner, 0);
    chk("wd_next_wait", req_wait, 4'b1110);
    // block write by requester 0
    cyc(); req_ren = '0; ramstate = BUSY;
    req_wen[0] = 1'b1; req_blk[0] = 1'b1; req_addr[0] = 32'h20C; req_store[0] = 32'hDEAD_BEEF;
    cyc(); #2;
    chk("bw_addr0", ramaddr, 32'h208);
    chk("bw_wen0", ramWEN, 1'b1);
    chk("bw_store", ramstore, 32'hDEAD_BEEF);
    cyc(); ramstate = ACCESS; #2;
    chk("bw_wait0", req_wait, 4'b1110);
    cyc(); ramstate = BUSY; #2;
    chk("bw_addr1", ramaddr, 32'h20C);
    chk("bw_wen1", ramWEN, 1'b1);
    cyc(); ramstate = ACCESS; #2;
    chk("bw_wait1", req_wait, 4'b1110);
    cyc(); req_wen = '0; req_blk = '0; ramstate = BUSY; #2;
    chk("bw_done", busy, 1'b0);
    // block read by requester 1 hit by ERROR in its second word
    req_ren[1] = 1'b1; req_blk[1] = 1'b1; req_addr[1] = 32'h300;
    cyc(); ramstate = ACCESS; #2;
    chk("er_wait0", req_wait, 4'b1101);
    chk("er_addr0", ramaddr, 32'h300);
    cyc(); ramstate = ERROR; #2;
    chk("er_err", req_err, 4'b0010);
    chk("er_wait1", req_wait, 4'hF);
    chk("er_addr1", ramaddr, 32'h304);
    cyc(); ramstate = BUSY; req_ren = '0; req_blk = '0; #2;
    chk("er_idle", busy, 1'b0);
    chk("er_ren", ramREN, 1'b0);
    // timeout: RAM stuck BUSY, abort in the 4th waiting cycle
    req_ren[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(); #2;
      chk("to_noerr", req_err, 4'h0);
    end
    cyc(); #2;
    chk("to_err", req_err, 4'b0100);
    chk("to_wait", req_wait, 4'hF);
    cyc(); req_ren = '0; #2;
    chk("to_idle", busy, 1'b0);
    // reset in the middle of a block's second word
    req_ren[1] = 1'b1; req_blk[1] = 1'b1;
    cyc(); ramstate = ACCESS;
    cyc(); ramstate = BUSY; #1;
    chk("rs_word1", ramaddr, 32'h304);
    nRST = 1'b0; #1;
    chk("rs_busy", busy, 1'b0);
    chk("rs_ren", ramREN, 1'b0);
    chk("rs_addr", ramaddr, 32'h0);
    chk("rs_owner", owner, 0);
    chk("rs_wait", req_wait, 4'hF);
    cyc(); nRST = 1'b1; req_ren = 4'b1001; req_blk = '0; ramstate = ACCESS;
    cyc(); #2;
    chk("rs_ptr_owner", owner, 0);
    chk("rs_ptr_wait", req_wait, 4'b1110);
    cyc(); req_ren = '0;
    repeat (2) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the single RAM port among NREQ requesters (I-caches, D-caches, DMA).
- Each granted requester performs either a single-word access or an aligned two-word block access.
- The requester holds the grant until the transaction completes, errors, times out or is withdrawn.
- Sits between requester-side wait/load handshakes and the RAM's ramstate handshake.

Parameters:
NREQ, 4, number of requesters (power of two, >=2)
AW, 32, address width
DW, 32, data width
TIMEOUT, 64, max wait cycles per word before abort (>=2)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
req_ren  input  NREQ  per-requester read request
req_wen  input  NREQ  per-requester write request (wins over req_ren in the same requester)
req_blk  input  NREQ  1 = two-word block (address forced to 8-byte alignment), 0 = single word
req_addr  input  [NREQ-1:0][AW-1:0]  byte address
req_store  input  [NREQ-1:0][DW-1:0]  write data
req_wait  output  NREQ  1 = stall; 0 for exactly one cycle per completed word
req_load  output  [NREQ-1:0][DW-1:0]  read data, valid when req_wait=0
req_err  output  NREQ  one-cycle abort pulse (RAM ERROR or timeout)
ramstate  input  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3
ramload  input  DW  RAM read data
ramREN  output  1  RAM read enable
ramWEN  output  1  RAM write enable
ramaddr  output  AW  RAM address
ramstore  output  DW  RAM write data
busy  output  1  transaction in progress (state != IDLE)
owner  output  clog2(NREQ)  index of current or last grantee

Behaviour:
- Reset (async, nRST=0) forces:
  - state=IDLE, rr_ptr=0, owner=0, wdog=0.
  - ramREN=ramWEN=0, ramaddr=0, ramstore=0.
  - req_wait all 1, req_load all 0, req_err all 0, busy=0.
  - Reset mid-transaction aborts immediately; no err pulse.
- States: IDLE, WORD0, WORD1.
- IDLE:
  - No RAM enables asserted.
  - Scan requesters with (ren|wen) in order rr_ptr, rr_ptr+1, ... mod NREQ.
  - Latch the first hit as owner, plus its op (write if wen) and blk. Next state WORD0.
  - Arbitration latency is 1 cycle: the RAM is driven the cycle after the request is seen.
- WORD0:
  - ramREN/ramWEN per latched op.
  - ramaddr = blk ? {addr[AW-1:3],3'b000} : addr.
  - ramstore = req_store[owner]; req_load[owner] = ramload (all non-owner loads 0).
  - On ramstate==ACCESS: req_wait[owner]=0 that cycle, then go to WORD1 if blk, else complete.
- WORD1:
  - Same drive as WORD0 with ramaddr = {addr[AW-1:3],3'b100}.
  - On ACCESS: req_wait[owner]=0, then complete.
- Complete / abort: next state IDLE, rr_ptr = owner+1 (wraps NREQ-1 -> 0). The last grantee gets lowest priority.
- FREE/BUSY in WORD0/WORD1: hold the state and all outputs. wdog increments each such cycle.
- wdog clears on entry to each word and on ACCESS.
- Abort on ramstate==ERROR, or wdog reaching TIMEOUT-1 without ACCESS:
  - req_err[owner]=1 for that cycle; req_wait stays 1.
  - RAM enables deassert next cycle; go to IDLE and advance rr_ptr.
- Withdrawal: if the owner drops both ren and wen during WORD0/WORD1, RAM enables deassert that same cycle (combinationally gated). Go to IDLE, advance rr_ptr, no err.
- req_addr and req_store are sampled live from the owner each cycle. Requesters must hold them stable until req_wait=0.
- A write op ignores ramload; a read op drives ramstore=0.
- Non-owner requesters: req_wait=1, req_err=0 at all times.
- Back-to-back: the owner may re-request in the completion cycle, but it is re-arbitrated behind the others.

Test Plan:
- Single read: req_ren[2]=1, blk=0, addr=0x104, ACCESS on 3rd cycle -> ramREN=1 with ramaddr=0x104 from cycle 1; req_wait[2]=0 for one cycle with req_load[2]=ramload; rr_ptr=3.
- Block write: req_wen[0]=1, blk=1, addr=0x20C -> ramaddr 0x208 then 0x20C; two req_wait[0] low pulses; ramWEN high throughout; busy low after second ACCESS.
- Fairness: all four requesters ren continuously, blk=0 -> grant order 0,1,2,3,0; no requester waits more than 4 transactions.
- Error and timeout:
  - ramstate=ERROR in WORD1 of a block read by req 1 -> req_err[1] pulse, only one req_wait[1] low, IDLE next.
  - TIMEOUT=4 with ramstate stuck BUSY -> req_err pulse after 4 wait cycles.
- Withdrawal and reset:
  - Owner 3 drops ren in WORD0 -> ramREN=0 same cycle, no err, next grant goes to requester 0.
  - nRST low mid-WORD1 -> all outputs return to reset values immediately; rr_ptr=0.
